uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter sharing the single 115200-baud UART_TX instance between NUM_REQ byte sources, such as RX loopback echo, a status reporter and a debug dump. The arbiter sits between the requesters and UART_TX. It keeps multi-byte messages atomic by locking the grant until the requester's last byte. A lock timeout prevents a stalled requester from starving the others.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- LOCK_TIMEOUT, 4096: idle clocks tolerated inside a locked message before forced release, ≥1
- i_Clk  in  1  main 25 MHz clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_Req_DV  in  NUM_REQ  per-requester byte valid; held until acked
- i_Req_Byte  in  8*NUM_REQ  requester k byte at [8k+7:8k]; stable while DV high
- i_Req_Last  in  NUM_REQ  byte is final byte of message; sampled with DV
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte accepted
- o_Grant  out  NUM_REQ  one-hot current owner; 0 when idle
- o_TX_DV  out  1  one-cycle start pulse to UART_TX i_DV
- o_TX_Byte  out  8  byte to UART_TX i_TX_Byte, registered
- i_TX_Active  in  1  UART_TX busy
- i_TX_Done  in  1  UART_TX one-cycle completion pulse
- o_Busy  out  1  state ≠ IDLE
- o_Lock_Abort  out  1  one-cycle pulse on timeout release

## Operation
- States: IDLE, SEND, HOLD.
- IDLE, when any i_Req_DV is high and i_TX_Active is low:
  - Pick the first set request scanning from r_Ptr upward, with wrap.
  - Register o_TX_Byte, pulse o_TX_DV and o_Req_Ack[g], capture r_Last = i_Req_Last[g], set o_Grant, go to SEND.
  - If i_TX_Active is high, wait. No ack is issued.
- SEND:
  - Ignore all requests.
  - On i_TX_Done with r_Last=1: r_Ptr ← (g+1) mod NUM_REQ, clear o_Grant, go to IDLE.
  - On i_TX_Done with r_Last=0: clear the timeout counter, go to HOLD.
- HOLD:
  - Only requester g is eligible. Other DVs are ignored.
  - i_Req_DV[g] high: issue exactly as in IDLE and return to SEND.
  - Otherwise increment the counter. When it reaches LOCK_TIMEOUT-1: pulse o_Lock_Abort, advance r_Ptr past g, clear o_Grant, go to IDLE.
- i_TX_Done outside SEND is ignored.
- A requester dropping DV before ack is legal. Nothing is sent.
- The cycle after ack, the requester may present its next byte or drop DV. A still-high DV is treated as a new byte.
- Reset values:
  - State IDLE, r_Ptr 0, counter 0.
  - All outputs 0, o_TX_Byte 8'h00.
- Reset mid-message: the message is abandoned with no abort pulse.
  - UART_TX has no reset, so after reset the arbiter issues nothing until i_TX_Active is low.
- Counter width is $clog2(LOCK_TIMEOUT+1). It saturates, and never wraps.

## Timing
- Request high sampled at edge N in IDLE/HOLD → o_TX_DV, o_Req_Ack and o_Grant valid in cycle N+1.
- i_TX_Done at edge M → IDLE/HOLD from M+1. The earliest next o_TX_DV is M+2.
- Back-to-back bytes of one message have no arbitration bubble beyond that 1 cycle.
- o_TX_DV and o_Req_Ack are always coincident and never high two consecutive cycles.
- Byte throughput is bounded by UART_TX at about 2170 clocks per byte at CLKS_PER_BIT=217.

## Structure
- Package uart_arb_pkg holds:
  - the state enum (IDLE, SEND, HOLD);
  - the NUM_REQ range check constants;
  - a function returning the timeout counter width.
- Sub-module rr_pick is a combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and valid.
  - Instantiate it once; HOLD masks its input to the owner's bit.
- Only registered outputs drive UART_TX.

## Test plan
- Single byte: requester 0 sends 8'h41 with Last=1 → one o_TX_DV, o_TX_Byte=8'h41, ack 1 cycle after DV, r_Ptr=1 after Done.
- Fairness: both requesters hold DV continuously with Last=1, 6 bytes → grants alternate 0,1,0,1,0,1.
- Atomic message: requester 1 sends "OK\n" (Last only on 8'h0A) while requester 0 requests → 8'h4F, 8'h4B, 8'h0A sent before any requester 0 byte.
- Timeout: LOCK_TIMEOUT=16, requester 0 sends one byte with Last=0 then idles → o_Lock_Abort pulses 16 cycles after Done, requester 1 is granted next cycle.
- TX busy at reset: i_TX_Active held high 100 cycles after i_Rst falls, with DV pending → no o_TX_DV until Active drops, then 1 cycle later.
- Reset mid-SEND: assert i_Rst during transmission → all outputs 0 immediately (async), state IDLE, no o_Lock_Abort.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and elaboration helpers for the UART TX arbiter.
// Holds the FSM state encoding, NUM_REQ limits and timeout counter sizing.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

  // Wide enough to hold LOCK_TIMEOUT itself, so the saturating compare never wraps.
  function automatic int unsigned timeout_cnt_width(input int unsigned lock_timeout);
    return $clog2(lock_timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Returns a one-hot grant and a valid flag.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  logic [N-1:0] mask_ge;
  logic [N-1:0] req_hi;

  // Lowest set bit of the requests at/above ptr, else lowest set bit overall.
  always_comb begin
    mask_ge = ~((N'(1) << ptr) - N'(1));
    req_hi  = req & mask_ge;
    if (req_hi != '0) begin
      grant = req_hi & (~req_hi + N'(1));
    end else begin
      grant = req & (~req + N'(1));
    end
    valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between NUM_REQ byte sources.
// Grant is locked until the owner's last byte, with an idle timeout release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [NUM_REQ-1:0]     i_Req_DV,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ack,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_Busy,
  output logic                   o_Lock_Abort
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = timeout_cnt_width(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_e         state, state_nxt;
  logic [PW-1:0]      r_Ptr, ptr_nxt;
  logic [PW-1:0]      r_Owner, owner_nxt, owner_inc;
  logic               r_Last, last_nxt;
  logic [CW-1:0]      r_Cnt, cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
  logic               tx_dv_nxt, abort_nxt;
  logic [7:0]         tx_byte_nxt;

  logic [NUM_REQ-1:0] pick_req, pick_grant;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic [7:0]         pick_byte;
  logic               pick_last;
  logic               issue;

  // In HOLD only the current owner may reach the picker.
  assign pick_req = (state == HOLD) ? (i_Req_DV & o_Grant) : i_Req_DV;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req   (pick_req),
    .ptr   (r_Ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_byte = '0;
    pick_last = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_grant[k]) begin
        pick_idx  = PW'(k);
        pick_byte = i_Req_Byte[8*k +: 8];
        pick_last = i_Req_Last[k];
      end
    end
  end

  assign owner_inc = (r_Owner == PW'(NUM_REQ - 1)) ? '0 : r_Owner + PW'(1);
  assign issue     = pick_valid && !i_TX_Active;
  assign o_Busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = r_Ptr;
    owner_nxt   = r_Owner;
    last_nxt    = r_Last;
    cnt_nxt     = r_Cnt;
    grant_nxt   = o_Grant;
    ack_nxt     = '0;
    tx_dv_nxt   = 1'b0;
    tx_byte_nxt = o_TX_Byte;
    abort_nxt   = 1'b0;

    case (state)
      IDLE, HOLD: begin
        if (issue) begin
          ack_nxt     = pick_grant;
          grant_nxt   = pick_grant;
          tx_dv_nxt   = 1'b1;
          tx_byte_nxt = pick_byte;
          last_nxt    = pick_last;
          owner_nxt   = pick_idx;
          state_nxt   = SEND;
        end else if (state == HOLD) begin
          if (r_Cnt >= CNT_LAST) begin
            abort_nxt = 1'b1;
            ptr_nxt   = owner_inc;
            grant_nxt = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = r_Cnt + CW'(1);
          end
        end
      end
      SEND: begin
        if (i_TX_Done) begin
          if (r_Last) begin
            ptr_nxt   = owner_inc;
            grant_nxt = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= IDLE;
      r_Ptr        <= '0;
      r_Owner      <= '0;
      r_Last       <= 1'b0;
      r_Cnt        <= '0;
      o_Grant      <= '0;
      o_Req_Ack    <= '0;
      o_TX_DV      <= 1'b0;
      o_TX_Byte    <= 8'h00;
      o_Lock_Abort <= 1'b0;
    end else begin
      state        <= state_nxt;
      r_Ptr        <= ptr_nxt;
      r_Owner      <= owner_nxt;
      r_Last       <= last_nxt;
      r_Cnt        <= cnt_nxt;
      o_Grant      <= grant_nxt;
      o_Req_Ack    <= ack_nxt;
      o_TX_DV      <= tx_dv_nxt;
      o_TX_Byte    <= tx_byte_nxt;
      o_Lock_Abort <= abort_nxt;
    end
  end

endmodule
